multicycle_control_unit: RTL and testbench

Parametrised multi-cycle successor to the single-cycle opcode decoder of the 16-bit RISC processor. An FSM steps each instruction through FETCH/DECODE/EXEC/MEM/WB and issues per-state datapath controls. It adds a ready handshake with data memory, an optional memory timeout, illegal-opcode detection and instruction-complete pulses. It sits between the instruction register and the shared datapath (PC, register file, ALU, data memory).

---
 rtl/multicycle_control_unit.sv | 195 +++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM for the 16-bit RISC datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the
// per-state datapath controls, with a data-memory ready handshake, an
// optional memory wait timeout and illegal-opcode detection.
module multicycle_control_unit #(
  parameter int OPCODE_W    = 4,
  parameter int ALU_OP_W    = 2,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                ir_write,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_src,
  output logic                reg_des,
  output logic                mem_reg,
  output logic                reg_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                instr_done,
  output logic                illegal_op,
  output logic                bus_error,
  output logic [2:0]          state
);

  // Wait counter must be able to hold MEM_TIMEOUT; keep at least one bit.
  localparam int CNT_W = ($clog2(MEM_TIMEOUT + 1) < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  localparam logic [ALU_OP_W-1:0] ALU_RTYPE = ALU_OP_W'(2'b00);
  localparam logic [ALU_OP_W-1:0] ALU_SUB   = ALU_OP_W'(2'b01);
  localparam logic [ALU_OP_W-1:0] ALU_ADDR  = ALU_OP_W'(2'b10);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [OPCODE_W-1:0] r_op_q;
  logic [CNT_W-1:0]    r_wait_cnt;

  logic w_is_lw;
  logic w_is_sw;
  logic w_is_rtype;
  logic w_is_beq;
  logic w_is_bne;
  logic w_is_jmp;
  logic w_timeout;

  // Classify the latched opcode; anything not matched below is illegal.
  assign w_is_lw    = (r_op_q == OPCODE_W'(0));
  assign w_is_sw    = (r_op_q == OPCODE_W'(1));
  assign w_is_rtype = (r_op_q >= OPCODE_W'(2)) && (r_op_q <= OPCODE_W'(9));
  assign w_is_beq   = (r_op_q == OPCODE_W'(10));
  assign w_is_bne   = (r_op_q == OPCODE_W'(11));
  assign w_is_jmp   = (r_op_q == OPCODE_W'(12));

  // Abort only when the limit is reached and memory still is not ready;
  // a ready in the same cycle takes priority.
  assign w_timeout = (MEM_TIMEOUT > 0) && (r_wait_cnt == CNT_W'(MEM_TIMEOUT)) && !mem_ready;

  assign state = r_state;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Latch the opcode once per instruction, during DECODE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op_q <= '0;
    end else if (r_state == S_DECODE) begin
      r_op_q <= opcode;
    end
  end

  // MEM wait counter: zero outside MEM, counts not-ready MEM cycles, saturates.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_cnt <= '0;
    end else if (r_state != S_MEM) begin
      r_wait_cnt <= '0;
    end else if (!mem_ready && (r_wait_cnt != {CNT_W{1'b1}})) begin
      r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end
  end

  // Next-state and control decode; all controls are held low during reset.
  always_comb begin
    w_next_state = S_FETCH;
    pc_write     = 1'b0;
    pc_src       = 2'b00;
    ir_write     = 1'b0;
    alu_op       = ALU_RTYPE;
    alu_src      = 1'b0;
    reg_des      = 1'b0;
    mem_reg      = 1'b0;
    reg_write    = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    instr_done   = 1'b0;
    illegal_op   = 1'b0;
    bus_error    = 1'b0;

    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          ir_write     = 1'b1;
          pc_write     = 1'b1;
          pc_src       = 2'b00;
          w_next_state = S_DECODE;
        end

        S_DECODE: begin
          w_next_state = S_EXEC;
        end

        S_EXEC: begin
          if (w_is_lw || w_is_sw) begin
            alu_src      = 1'b1;
            alu_op       = ALU_ADDR;
            w_next_state = S_MEM;
          end else if (w_is_rtype) begin
            reg_des      = 1'b1;
            alu_op       = ALU_RTYPE;
            w_next_state = S_WB;
          end else if (w_is_beq || w_is_bne) begin
            alu_op       = ALU_SUB;
            pc_src       = 2'b01;
            pc_write     = w_is_beq ? zero : ~zero;
            instr_done   = 1'b1;
            w_next_state = S_FETCH;
          end else if (w_is_jmp) begin
            pc_write     = 1'b1;
            pc_src       = 2'b10;
            instr_done   = 1'b1;
            w_next_state = S_FETCH;
          end else begin
            illegal_op   = 1'b1;
            w_next_state = S_FETCH;
          end
        end

        S_MEM: begin
          alu_src = 1'b1;
          alu_op  = ALU_ADDR;
          if (mem_ready) begin
            mem_read  = w_is_lw;
            mem_write = w_is_sw;
            if (w_is_lw) begin
              w_next_state = S_WB;
            end else begin
              instr_done   = 1'b1;
              w_next_state = S_FETCH;
            end
          end else if (w_timeout) begin
            bus_error    = 1'b1;
            w_next_state = S_FETCH;
          end else begin
            mem_read     = w_is_lw;
            mem_write    = w_is_sw;
            w_next_state = S_MEM;
          end
        end

        S_WB: begin
          reg_write    = 1'b1;
          instr_done   = 1'b1;
          mem_reg      = w_is_lw;
          reg_des      = ~w_is_lw;
          w_next_state = S_FETCH;
        end

        default: begin
          w_next_state = S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed testbench for multicycle_control_unit (default parameters).
module tb_multicycle_control_unit;

  logic       clk;
  logic       reset;
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       ir_write;
  logic [1:0] alu_op;
  logic       alu_src;
  logic       reg_des;
  logic       mem_reg;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic       instr_done;
  logic       illegal_op;
  logic       bus_error;
  logic [2:0] state;

  int checks;
  int errors;

  wire [14:0] ctrl = {pc_write, pc_src, ir_write, alu_op, alu_src, reg_des, mem_reg,
                      reg_write, mem_read, mem_write, instr_done, illegal_op, bus_error};

  multicycle_control_unit #(
    .OPCODE_W(4),
    .ALU_OP_W(2),
    .MEM_TIMEOUT(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .opcode(opcode),
    .zero(zero),
    .mem_ready(mem_ready),
    .pc_write(pc_write),
    .pc_src(pc_src),
    .ir_write(ir_write),
    .alu_op(alu_op),
    .alu_src(alu_src),
    .reg_des(reg_des),
    .mem_reg(mem_reg),
    .reg_write(reg_write),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .instr_done(instr_done),
    .illegal_op(illegal_op),
    .bus_error(bus_error),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Move to 1 time unit after the next rising edge.
  task automatic advance;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; opcode = 4'd0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    mem_ready = 1'b1; opcode = 4'd1;
    @(negedge clk);
    checks++;
    if (state !== 3'd0) begin
      errors++; $display("FAIL reset_state: got %0d want 0", state);
    end
    checks++;
    if (ctrl !== 15'd0) begin
      errors++; $display("FAIL reset_ctrl: got %h want 0", ctrl);
    end
    advance();
    reset = 1'b0; mem_ready = 1'b0;
    $display("txn reset: released");
  endtask

  task automatic test_rtype;
    logic [2:0] exp_st [0:3];
    exp_st = '{3'd0, 3'd1, 3'd2, 3'd4};
    opcode = 4'd2;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (state !== exp_st[c]) begin
        errors++; $display("FAIL rtype_state c%0d: got %0d want %0d", c, state, exp_st[c]);
      end
      checks++;
      if (reg_write !== (c == 3) || instr_done !== (c == 3) || reg_des !== (c >= 2)) begin
        errors++;
        $display("FAIL rtype_ctrl c%0d: got rw=%b done=%b rd=%b want rw=%b done=%b rd=%b",
                 c, reg_write, instr_done, reg_des, (c == 3), (c == 3), (c >= 2));
      end
      if (c == 0) begin
        checks++;
        if (ir_write !== 1'b1 || pc_write !== 1'b1 || pc_src !== 2'b00) begin
          errors++; $display("FAIL fetch_ctrl: got ir=%b pcw=%b src=%b want 1 1 00", ir_write, pc_write, pc_src);
        end
      end
      advance();
    end
    checks++;
    if (state !== 3'd0) begin
      errors++; $display("FAIL rtype_end: got %0d want 0", state);
    end
    $display("txn rtype op=2 complete");
  endtask

  task automatic test_lw_wait;
    logic [2:0] exp_st [0:7];
    exp_st = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
    opcode = 4'd0;
    for (int c = 0; c < 8; c++) begin
      mem_ready = (c == 6);
      @(negedge clk);
      checks++;
      if (state !== exp_st[c]) begin
        errors++; $display("FAIL lw_state c%0d: got %0d want %0d", c, state, exp_st[c]);
      end
      checks++;
      if (mem_read !== (c >= 3 && c <= 6) || mem_reg !== (c == 7) ||
          reg_write !== (c == 7) || instr_done !== (c == 7)) begin
        errors++;
        $display("FAIL lw_ctrl c%0d: got rd=%b mr=%b rw=%b done=%b", c, mem_read, mem_reg, reg_write, instr_done);
      end
      advance();
    end
    mem_ready = 1'b0;
    checks++;
    if (state !== 3'd0) begin
      errors++; $display("FAIL lw_end: got %0d want 0", state);
    end
    $display("txn lw waits=3 complete");
  endtask

  task automatic test_sw;
    opcode = 4'd1;
    mem_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (state !== 3'(c)) begin
        errors++; $display("FAIL sw_state c%0d: got %0d want %0d", c, state, c);
      end
      checks++;
      if (mem_write !== (c == 3) || instr_done !== (c == 3) || reg_write !== 1'b0 || mem_read !== 1'b0) begin
        errors++;
        $display("FAIL sw_ctrl c%0d: got wr=%b done=%b rw=%b rd=%b", c, mem_write, instr_done, reg_write, mem_read);
      end
      advance();
    end
    mem_ready = 1'b0;
    checks++;
    if (state !== 3'd0) begin
      errors++; $display("FAIL sw_end: got %0d want 0", state);
    end
    $display("txn sw ready-on-entry complete");
  endtask

  task automatic test_branches;
    logic [3:0] ops  [0:4];
    logic       zs   [0:4];
    logic       pcw  [0:4];
    logic [1:0] srcs [0:4];
    logic [1:0] aops [0:4];
    ops  = '{4'd10, 4'd10, 4'd11, 4'd11, 4'd12};
    zs   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    pcw  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    srcs = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    aops = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
    for (int k = 0; k < 5; k++) begin
      opcode = ops[k];
      zero = zs[k];
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        checks++;
        if (state !== 3'(c)) begin
          errors++; $display("FAIL br%0d_state c%0d: got %0d want %0d", k, c, state, c);
        end
        if (c == 2) begin
          checks++;
          if (pc_write !== pcw[k] || pc_src !== srcs[k] || alu_op !== aops[k] || instr_done !== 1'b1) begin
            errors++;
            $display("FAIL br%0d_exec: got pcw=%b src=%b aop=%b done=%b want pcw=%b src=%b aop=%b done=1",
                     k, pc_write, pc_src, alu_op, instr_done, pcw[k], srcs[k], aops[k]);
          end
        end
        advance();
      end
      checks++;
      if (state !== 3'd0) begin
        errors++; $display("FAIL br%0d_end: got %0d want 0", k, state);
      end
      $display("txn op=%0d zero=%b pc_write=%b", ops[k], zs[k], pcw[k]);
    end
    zero = 1'b0;
  endtask

  task automatic test_illegal;
    logic [3:0] ops [0:2];
    ops = '{4'd13, 4'd14, 4'd15};
    for (int k = 0; k < 3; k++) begin
      opcode = ops[k];
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        checks++;
        if (state !== 3'(c) || illegal_op !== (c == 2)) begin
          errors++; $display("FAIL ill%0d c%0d: got st=%0d ill=%b want st=%0d ill=%b", k, c, state, illegal_op, c, (c == 2));
        end
        checks++;
        if (reg_write !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0 || instr_done !== 1'b0) begin
          errors++;
          $display("FAIL ill%0d_side c%0d: got rw=%b rd=%b wr=%b done=%b want 0", k, c, reg_write, mem_read, mem_write, instr_done);
        end
        advance();
      end
      checks++;
      if (state !== 3'd0) begin
        errors++; $display("FAIL ill%0d_end: got %0d want 0", k, state);
      end
      $display("txn illegal op=%0d", ops[k]);
    end
  endtask

  task automatic test_timeout(input bit ready_last);
    opcode = 4'd0;
    mem_ready = 1'b0;
    advance(); advance(); advance();
    for (int m = 1; m <= 17; m++) begin
      mem_ready = ready_last && (m == 17);
      @(negedge clk);
      checks++;
      if (state !== 3'd3 || instr_done !== 1'b0) begin
        errors++; $display("FAIL to_state m%0d: got st=%0d done=%b want 3 0", m, state, instr_done);
      end
      checks++;
      if (mem_read !== (m < 17 || ready_last) || bus_error !== (m == 17 && !ready_last)) begin
        errors++;
        $display("FAIL to_ctrl m%0d rl=%b: got rd=%b be=%b want rd=%b be=%b", m, ready_last, mem_read, bus_error,
                 (m < 17 || ready_last), (m == 17 && !ready_last));
      end
      advance();
    end
    mem_ready = 1'b0;
    if (!ready_last) begin
      checks++;
      if (state !== 3'd0) begin
        errors++; $display("FAIL to_abort_next: got %0d want 0", state);
      end
    end else begin
      @(negedge clk);
      checks++;
      if (state !== 3'd4 || reg_write !== 1'b1 || mem_reg !== 1'b1 || instr_done !== 1'b1 || bus_error !== 1'b0) begin
        errors++;
        $display("FAIL to_wb: got st=%0d rw=%b mr=%b done=%b be=%b want 4 1 1 1 0", state, reg_write, mem_reg, instr_done, bus_error);
      end
      advance();
      checks++;
      if (state !== 3'd0) begin
        errors++; $display("FAIL to_wb_end: got %0d want 0", state);
      end
    end
    $display("txn lw timeout ready_last=%b", ready_last);
  endtask

  task automatic test_reset_mid;
    opcode = 4'd0;
    mem_ready = 1'b0;
    advance(); advance(); advance(); advance();
    checks++;
    if (state !== 3'd3) begin
      errors++; $display("FAIL rm_pre: got %0d want 3", state);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (ctrl !== 15'd0) begin
      errors++; $display("FAIL rm_forced: got %h want 0", ctrl);
    end
    advance();
    checks++;
    if (state !== 3'd0) begin
      errors++; $display("FAIL rm_state: got %0d want 0", state);
    end
    @(negedge clk);
    checks++;
    if (instr_done !== 1'b0 || bus_error !== 1'b0) begin
      errors++; $display("FAIL rm_pulse: got done=%b be=%b want 0 0", instr_done, bus_error);
    end
    advance();
    reset = 1'b0;
    $display("txn reset during MEM");
    test_rtype();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw();
    test_branches();
    test_illegal();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
